// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display driver.
// Holds the display mode encoding and the fixed active-low patterns.
package sseg_pkg;

  typedef enum logic [1:0] {
    MODE_HEX   = 2'b00,
    MODE_ANIM  = 2'b01,
    MODE_BLANK = 2'b10
  } mode_t;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_UPPER = 8'h9C;
  localparam logic [7:0] SSEG_LOWER = 8'hA3;

endpackage

// File: rtl/sseg_anim_mux_hex_to_sseg.sv
// Hex nibble to active-low seven-segment font {g,f,e,d,c,b,a}.
// Ports: hex (4-bit value in), seg (7-bit active-low pattern out).
module hex_to_sseg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/sseg_anim_mux.sv
// N-digit multiplexed 7-seg driver: HEX scan, circulating square, blank.
// Ports: clk, reset (async active-low), en, mode, dir, hex_in, dp_in,
// [blink_mask when SSEG_BLINK_EN], an, sseg, frame_done.
module sseg_anim_mux
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int STEP_DIV    = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    dir,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
`ifdef SSEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              sseg,
  output logic                    frame_done
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(2 * NUM_DIGITS);
  localparam int TW = $clog2(STEP_DIV);

  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(2 * NUM_DIGITS - 1);
  localparam logic [PW-1:0] N_P      = PW'(NUM_DIGITS);
  localparam logic [PW-1:0] N_M1     = PW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] STEP_MAX = TW'(STEP_DIV - 1);

  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic [RW-1:0] ref_cnt;
  logic [SW-1:0] scan_idx;
  logic [TW-1:0] step_cnt, step_d;
  logic [PW-1:0] pos, pos_d;
  logic          fd_d;

  logic [NUM_DIGITS-1:0] an_d;
  logic [7:0]            sseg_d;
  logic [6:0]            font;
  logic [SW-1:0]         anim_dig;
  logic                  upper;

  mode_t md;
  logic  is_hex, is_anim, step_term;

`ifdef SSEG_BLINK_EN
  logic blink_phase, blink_d;
`endif

  // Reserved encoding 2'b11 collapses onto BLANK
  always_comb begin
    md = MODE_BLANK;
    if (mode == 2'b00) md = MODE_HEX;
    if (mode == 2'b01) md = MODE_ANIM;
  end

  assign is_hex    = (md == MODE_HEX);
  assign is_anim   = (md == MODE_ANIM);
  assign step_term = (step_cnt == STEP_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
    end else if (ref_cnt == REF_MAX) begin
      ref_cnt  <= '0;
      scan_idx <= (scan_idx == SCAN_MAX) ? '0 : scan_idx + 1'b1;
    end else begin
      ref_cnt  <= ref_cnt + 1'b1;
    end
  end

  always_comb begin
    step_d = step_cnt;
    pos_d  = pos;
    fd_d   = 1'b0;
`ifdef SSEG_BLINK_EN
    blink_d = is_hex ? blink_phase : 1'b0;
`endif
    unique case (1'b1)
      is_anim: begin
        if (en) begin
          if (step_term) begin
            step_d = '0;
            if (dir) begin
              pos_d = (pos == '0) ? POS_MAX : pos - 1'b1;
              fd_d  = (pos == '0);
            end else begin
              pos_d = (pos == POS_MAX) ? '0 : pos + 1'b1;
              fd_d  = (pos == POS_MAX);
            end
          end else begin
            step_d = step_cnt + 1'b1;
          end
        end
      end
`ifdef SSEG_BLINK_EN
      // Blink period reuses the step counter, ignoring en
      is_hex: begin
        pos_d = '0;
        if (step_term) begin
          step_d  = '0;
          blink_d = ~blink_phase;
        end else begin
          step_d = step_cnt + 1'b1;
        end
      end
`endif
      default: begin
        step_d = '0;
        pos_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt <= '0;
      pos      <= '0;
`ifdef SSEG_BLINK_EN
      blink_phase <= 1'b0;
`endif
    end else begin
      step_cnt <= step_d;
      pos      <= pos_d;
`ifdef SSEG_BLINK_EN
      blink_phase <= blink_d;
`endif
    end
  end

  hex_to_sseg u_font (
    .hex (hex_in[{scan_idx, 2'b00} +: 4]),
    .seg (font)
  );

  // Upper row runs left to right, lower row returns right to left
  assign upper    = (pos < N_P);
  assign anim_dig = upper ? SW'(N_M1 - pos) : SW'(pos - N_P);

  always_comb begin
    an_d   = '1;
    sseg_d = SSEG_BLANK;
    unique case (1'b1)
      is_hex: begin
        an_d   = ~(ONE << scan_idx);
        sseg_d = {~dp_in[scan_idx], font};
`ifdef SSEG_BLINK_EN
        if (blink_phase && blink_mask[scan_idx]) begin
          an_d   = '1;
          sseg_d = SSEG_BLANK;
        end
`endif
      end
      is_anim: begin
        an_d   = ~(ONE << anim_dig);
        sseg_d = upper ? SSEG_UPPER : SSEG_LOWER;
      end
      default: begin
        an_d   = '1;
        sseg_d = SSEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an         <= '1;
      sseg       <= SSEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      an         <= an_d;
      sseg       <= sseg_d;
      frame_done <= fd_d;
    end
  end

endmodule

// File: tb/tb_sseg_anim_mux.sv
// Randomised bench for sseg_anim_mux against a behavioural model.
// N=4, REFRESH_DIV=4, STEP_DIV=8; blink model follows SSEG_BLINK_EN.
module tb_sseg_anim_mux;

  localparam int N  = 4;
  localparam int RD = 4;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [1:0]    mode;
  logic          dir;
  logic [4*N-1:0] hex_in;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blink_mask;
  logic [N-1:0]  an;
  logic [7:0]    sseg;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: plain integers
  int m_scan, m_ref, m_step, m_pos, m_phase;
  logic [N-1:0] e_an;
  logic [7:0]   e_ss;
  logic         e_fd;
  int fd_cnt;

  logic [6:0] font [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 clk = ~clk;

  sseg_anim_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .STEP_DIV    (SD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .dir        (dir),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
`ifdef SSEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .an         (an),
    .sseg       (sseg),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan = 0; m_ref = 0; m_step = 0; m_pos = 0; m_phase = 0;
    e_an = '1; e_ss = 8'hFF; e_fd = 1'b0;
  endtask

  task automatic tick();
    int dig;
    logic [3:0] nib;
    @(posedge clk);
    e_an = '1;
    e_ss = 8'hFF;
    if (mode == 2'd0) begin
      nib = hex_in[m_scan*4 +: 4];
      e_an[m_scan] = 1'b0;
      e_ss = {~dp_in[m_scan], font[nib]};
`ifdef SSEG_BLINK_EN
      if (m_phase == 1 && blink_mask[m_scan]) begin
        e_an = '1;
        e_ss = 8'hFF;
      end
`endif
    end else if (mode == 2'd1) begin
      dig = (m_pos < N) ? N - 1 - m_pos : m_pos - N;
      e_an[dig] = 1'b0;
      e_ss = (m_pos < N) ? 8'h9C : 8'hA3;
    end
    e_fd = 1'b0;
    m_ref++;
    if (m_ref == RD) begin
      m_ref = 0;
      m_scan = (m_scan + 1) % N;
    end
    if (mode == 2'd1) begin
      m_phase = 0;
      if (en) begin
        m_step++;
        if (m_step == SD) begin
          m_step = 0;
          m_pos = dir ? m_pos - 1 : m_pos + 1;
          if (m_pos < 0 || m_pos == 2*N) e_fd = 1'b1;
          m_pos = (m_pos + 2*N) % (2*N);
        end
      end
`ifdef SSEG_BLINK_EN
    end else if (mode == 2'd0) begin
      m_pos = 0;
      m_step++;
      if (m_step == SD) begin
        m_step = 0;
        m_phase = 1 - m_phase;
      end
`endif
    end else begin
      m_step = 0; m_pos = 0; m_phase = 0;
    end
    @(negedge clk);
    chk("an", 32'(an), 32'(e_an));
    chk("sseg", 32'(sseg), 32'(e_ss));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (frame_done) fd_cnt++;
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; mode = 2'd0; dir = 1'b0;
    hex_in = 16'h1234; dp_in = 4'b0001; blink_mask = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_sseg", 32'(sseg), 32'hFF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    reset = 1'b1;

    // HEX digit 0 first, digit 3 after three full slots
    tick();
    chk("hex_d0_an", 32'(an), 32'hE);
    chk("hex_d0_sseg", 32'(sseg), 32'h19);
    repeat (12) tick();
    chk("hex_d3_an", 32'(an), 32'h7);
    chk("hex_d3_sseg", 32'(sseg), 32'hF9);
    repeat (2) tick();

    // Async reset mid-slot
    #2 reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'hF);
    chk("async_sseg", 32'(sseg), 32'hFF);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    tick();
    chk("post_rst_an", 32'(an), 32'hE);

    // ANIM forward: one full frame, one pulse
    mode = 2'd1; en = 1'b1; dir = 1'b0;
    fd_cnt = 0;
    tick();
    chk("fwd_first_an", 32'(an), 32'h7);
    chk("fwd_first_sseg", 32'(sseg), 32'h9C);
    repeat (63) tick();
    chk("fwd_fd_count", 32'(fd_cnt), 32'd1);

    // Reverse from pos 0 wraps to 7
    dir = 1'b1;
    repeat (8) tick();
    chk("rev_fd", 32'(frame_done), 32'h1);
    tick();
    chk("rev_an", 32'(an), 32'h7);
    chk("rev_sseg", 32'(sseg), 32'hA3);

    // Freeze
    en = 1'b0;
    fd_cnt = 0;
    repeat (40) tick();
    chk("frz_fd_count", 32'(fd_cnt), 32'd0);
    chk("frz_an", 32'(an), 32'h7);
    chk("frz_sseg", 32'(sseg), 32'hA3);

    // Walk to pos 5, blank one cycle, then restart
    en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 200 && m_pos != 5; i++) tick();
    chk("reach_pos5", 32'(m_pos), 32'd5);
    mode = 2'd2;
    tick();
    chk("sw_blank_an", 32'(an), 32'hF);
    chk("sw_blank_sseg", 32'(sseg), 32'hFF);
    mode = 2'd1;
    tick();
    chk("sw_restart_an", 32'(an), 32'h7);
    chk("sw_restart_sseg", 32'(sseg), 32'h9C);

`ifdef SSEG_BLINK_EN
    mode = 2'd0; blink_mask = 4'b0010;
    repeat (64) tick();
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      hex_in = 16'($urandom);
      dp_in  = 4'($urandom);
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 49) == 0) blink_mask = 4'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
